iob_rr_arbiter: RTL

- Round-robin arbiter that shares one IOb-bus slave port between N_MASTERS IOb-bus masters.
- Intended use: letting several IOb initiators (boot controller, DMA, debug port) reach a single peripheral or memory slave of the SoC.
- Serialises address phases, records which master owns each accepted read, and routes the delayed read responses (rvalid/rdata) back in order.

---
 rtl/iob_rr_arbiter_if.sv | 37 +++
 rtl/iob_rr_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/iob_rr_arbiter_if.sv
// IOb-bus bundle between N masters, the round-robin arbiter and one slave.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface iob_rr_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]          m_avalid_i;
    logic [N_MASTERS*ADDR_W-1:0]   m_addr_i;
    logic [N_MASTERS*DATA_W-1:0]   m_wdata_i;
    logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i;
    logic [N_MASTERS-1:0]          m_ready_o;
    logic [N_MASTERS-1:0]          m_rvalid_o;
    logic [DATA_W-1:0]             m_rdata_o;

    logic                          s_avalid_o;
    logic [ADDR_W-1:0]             s_addr_o;
    logic [DATA_W-1:0]             s_wdata_o;
    logic [DATA_W/8-1:0]           s_wstrb_o;
    logic                          s_ready_i;
    logic                          s_rvalid_i;
    logic [DATA_W-1:0]             s_rdata_i;

    modport slave (
        input  m_avalid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        input  s_ready_i, s_rvalid_i, s_rdata_i,
        output m_ready_o, m_rvalid_o, m_rdata_o,
        output s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o
    );

    modport master (
        output m_avalid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        output s_ready_i, s_rvalid_i, s_rdata_i,
        input  m_ready_o, m_rvalid_o, m_rdata_o,
        input  s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o
    );
endinterface

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave between N_MASTERS masters; a small
// ID FIFO remembers the owner of every accepted read so responses route back in order.
module iob_rr_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_RD_OUT = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    iob_rr_arbiter_if.slave              bus,
    output logic [$clog2(N_MASTERS)-1:0] grant_o,
    output logic                         err_o
);
    localparam int GW = $clog2(N_MASTERS);
    localparam int PW = $clog2(MAX_RD_OUT);
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] fifo_q [MAX_RD_OUT];
    logic [GW-1:0] fifo_d [MAX_RD_OUT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic          req_any;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          is_read;
    logic          fifo_full;
    logic          fifo_empty;
    logic          s_avalid;
    logic          accept;
    logic          push;
    logic          pop;
    logic [GW-1:0] head;

    // Datapath follows the granted master; in IDLE it simply keeps the last slice.
    always_comb begin
        bus.s_addr_o  = bus.m_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
        bus.s_wdata_o = bus.m_wdata_i[int'(grant_q)*DATA_W +: DATA_W];
        bus.s_wstrb_o = bus.m_wstrb_i[int'(grant_q)*SW +: SW];
        bus.m_rdata_o = bus.s_rdata_i;
    end

    // Round-robin search starts one past the last master that completed a request.
    always_comb begin
        req_any = 1'b0;
        pick    = last_grant_q;
        idx     = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = GW'((int'(last_grant_q) + k) % N_MASTERS);
            if (!req_any && bus.m_avalid_i[idx]) begin
                req_any = 1'b1;
                pick    = idx;
            end
        end
    end

    assign is_read    = (bus.s_wstrb_o == '0);
    assign fifo_full  = (count_q == (PW+1)'(MAX_RD_OUT));
    assign fifo_empty = (count_q == '0);
    assign s_avalid   = (state_q == GRANT) && bus.m_avalid_i[grant_q] && !(is_read && fifo_full);
    assign accept     = s_avalid && bus.s_ready_i;
    assign pop        = bus.s_rvalid_i && !fifo_empty;
    assign head       = fifo_q[rd_ptr_q];

    assign bus.s_avalid_o = s_avalid;
    assign grant_o        = grant_q;
    assign err_o          = err_q;

    always_comb begin
        bus.m_ready_o  = '0;
        bus.m_rvalid_o = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            bus.m_ready_o[i]  = accept && (grant_q == GW'(i));
            bus.m_rvalid_o[i] = pop && (head == GW'(i));
        end
    end

    // Arbitration FSM: a dropped request while granted returns to IDLE without
    // crediting the master, so its turn is not consumed.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    push         = is_read;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (!bus.m_avalid_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant_q;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        err_d    = err_q | (bus.s_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_MASTERS - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < MAX_RD_OUT; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            fifo_q       <= fifo_d;
        end
    end
endmodule
